alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 14 +
 rtl/alu_arb_pick.sv | 28 ++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-channel ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ALU_W = 8;
    localparam int OPC_W = 3;
    localparam int CNT_W = 3;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selector for two requesters.
// ALU_ARB_FIXED_PRI_EN selects fixed priority (channel 0 wins); otherwise round-robin on rr_ptr.
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid,
`ifndef ALU_ARB_FIXED_PRI_EN
    input  logic       rr_ptr,
`endif
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req_valid;
`ifdef ALU_ARB_FIXED_PRI_EN
        gnt = req_valid[1] & ~req_valid[0];
`else
        // A lone requester always wins; rr_ptr only breaks ties.
        if (&req_valid) begin
            gnt = rr_ptr;
        end else begin
            gnt = req_valid[1];
        end
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: capture, execute for ALU_LAT+1 cycles, respond.
// Build macro ALU_ARB_FIXED_PRI_EN replaces round-robin arbitration with fixed channel-0 priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREQ    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ALU_W-1:0]   req_accum,
    input  logic [NREQ*ALU_W-1:0]   req_data,
    input  logic [NREQ*OPC_W-1:0]   req_opcode,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [ALU_W-1:0]        rsp_alu_out,
    output logic                    rsp_zero,
    output logic [ALU_W-1:0]        alu_accum,
    output logic [ALU_W-1:0]        alu_data,
    output logic [OPC_W-1:0]        alu_opcode,
    input  logic [ALU_W-1:0]        alu_result,
    input  logic                    alu_zero
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(ALU_LAT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_q, gnt_d;
    logic [ALU_W-1:0]   accum_q, accum_d;
    logic [ALU_W-1:0]   data_q, data_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [ALU_W-1:0]   rsp_alu_out_q, rsp_alu_out_d;
    logic               rsp_zero_q, rsp_zero_d;

    logic               pick_gnt;
    logic               pick_any;

`ifndef ALU_ARB_FIXED_PRI_EN
    logic               rr_ptr_q, rr_ptr_d;
`endif

    alu_arb_pick u_pick (
        .req_valid (req_valid),
`ifndef ALU_ARB_FIXED_PRI_EN
        .rr_ptr    (rr_ptr_q),
`endif
        .gnt       (pick_gnt),
        .any       (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        accum_d       = accum_q;
        data_d        = data_q;
        opcode_d      = opcode_q;
        rsp_alu_out_d = rsp_alu_out_q;
        rsp_zero_d    = rsp_zero_q;
`ifndef ALU_ARB_FIXED_PRI_EN
        rr_ptr_d      = rr_ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_gnt;
                    accum_d  = req_accum[int'(pick_gnt)*ALU_W +: ALU_W];
                    data_d   = req_data[int'(pick_gnt)*ALU_W +: ALU_W];
                    opcode_d = req_opcode[int'(pick_gnt)*OPC_W +: OPC_W];
                    cnt_d    = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // The ALU output is trusted only once inputs have been stable ALU_LAT cycles.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAT_C) begin
                    rsp_alu_out_d = alu_result;
                    rsp_zero_d    = alu_zero;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
`ifndef ALU_ARB_FIXED_PRI_EN
                    rr_ptr_d = ~gnt_q;
`endif
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gnt_q         <= 1'b0;
            accum_q       <= '0;
            data_q        <= '0;
            opcode_q      <= '0;
            rsp_alu_out_q <= '0;
            rsp_zero_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
            rr_ptr_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            accum_q       <= accum_d;
            data_q        <= data_d;
            opcode_q      <= opcode_d;
            rsp_alu_out_q <= rsp_alu_out_d;
            rsp_zero_q    <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRI_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    // Handshake strobes are decoded from state so an async reset drops them at once.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE && pick_any) begin
            req_ready[pick_gnt] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign rsp_alu_out = rsp_alu_out_q;
    assign rsp_zero    = rsp_zero_q;
    assign alu_accum   = accum_q;
    assign alu_data    = data_q;
    assign alu_opcode  = opcode_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with registered adder ALU stubs at ALU_LAT=1 and ALU_LAT=4.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  rv, rr, rdy, vld;
    logic [15:0] accum, data;
    logic [5:0]  opc;
    logic [7:0]  out, a_acc, a_dat, a_res;
    logic        zero, a_zero;
    logic [2:0]  a_opc;

    logic [1:0]  b_rv, b_rr, b_rdy, b_vld;
    logic [15:0] b_accum, b_data;
    logic [5:0]  b_opc;
    logic [7:0]  b_out, b_acc, b_dat, b_res;
    logic        b_zero, b_azero;
    logic [2:0]  b_aopc;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(1), .NREQ(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(rv), .req_ready(rdy),
        .req_accum(accum), .req_data(data), .req_opcode(opc),
        .rsp_valid(vld), .rsp_ready(rr), .rsp_alu_out(out), .rsp_zero(zero),
        .alu_accum(a_acc), .alu_data(a_dat), .alu_opcode(a_opc),
        .alu_result(a_res), .alu_zero(a_zero)
    );

    alu_arbiter #(.ALU_LAT(4), .NREQ(2)) u4 (
        .clk(clk), .reset(reset), .req_valid(b_rv), .req_ready(b_rdy),
        .req_accum(b_accum), .req_data(b_data), .req_opcode(b_opc),
        .rsp_valid(b_vld), .rsp_ready(b_rr), .rsp_alu_out(b_out), .rsp_zero(b_zero),
        .alu_accum(b_acc), .alu_data(b_dat), .alu_opcode(b_aopc),
        .alu_result(b_res), .alu_zero(b_azero)
    );

    // Registered adder standing in for the shared ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_res  <= 8'h00;
            a_zero <= 1'b0;
            b_res  <= 8'h00;
            b_azero <= 1'b0;
        end else begin
            a_res   <= a_acc + a_dat;
            a_zero  <= (8'(a_acc + a_dat) == 8'h00);
            b_res   <= b_acc + b_dat;
            b_azero <= (8'(b_acc + b_dat) == 8'h00);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [7:0] exp_o;

        reset = 1'b1;
        rv = 2'b00; rr = 2'b00; accum = '0; data = '0; opc = '0;
        b_rv = 2'b00; b_rr = 2'b00; b_accum = '0; b_data = '0; b_opc = '0;

        next(); #1;
        check("rst_req_ready", 32'(rdy), 32'h0);
        check("rst_rsp_valid", 32'(vld), 32'h0);
        check("rst_rsp_out", 32'(out), 32'h00);
        check("rst_rsp_zero", 32'(zero), 32'h0);
        check("rst_alu_bus", {a_acc, a_dat, 5'd0, a_opc, 8'd0}, 32'h0);

        // Single request on ch0, then ch0 backpressure while ch1 waits.
        next();
        reset = 1'b0;
        rv = 2'b01; accum[7:0] = 8'h12; data[7:0] = 8'h34; opc[2:0] = 3'b001;
        #1 check("single_req_ready", 32'(rdy), 32'h1);
        next(); rv = 2'b00; #1;
        check("single_exec_ready", 32'(rdy), 32'h0);
        check("single_alu_accum", 32'(a_acc), 32'h12);
        check("single_alu_data", 32'(a_dat), 32'h34);
        check("single_alu_opc", 32'(a_opc), 32'h1);
        check("single_c1_valid", 32'(vld), 32'h0);
        next(); #1;
        check("single_c2_valid", 32'(vld), 32'h0);
        check("single_c2_alu_accum", 32'(a_acc), 32'h12);
        next();
        rv = 2'b10; accum[15:8] = 8'hFF; data[15:8] = 8'h01; opc[5:3] = 3'b010;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(vld), 32'h1);
            check("bp_rsp_out", 32'(out), 32'h46);
            check("bp_rsp_zero", 32'(zero), 32'h0);
            check("bp_ch1_ready", 32'(rdy), 32'h0);
            next(); #1;
        end
        rr = 2'b01; #1;
        check("bp_hs_valid", 32'(vld), 32'h1);

        // Zero result on ch1; wrong-channel rsp_ready must be ignored.
        next(); rr = 2'b00; #1;
        check("zero_req_ready", 32'(rdy), 32'h2);
        check("zero_idle_valid", 32'(vld), 32'h0);
        next(); rv = 2'b00; #1;
        check("zero_alu_accum", 32'(a_acc), 32'hFF);
        check("zero_alu_opc", 32'(a_opc), 32'h2);
        next(); next(); #1;
        check("zero_rsp_valid", 32'(vld), 32'h2);
        check("zero_rsp_out", 32'(out), 32'h00);
        check("zero_rsp_zero", 32'(zero), 32'h1);
        rr = 2'b01;
        next(); #1;
        check("zero_wrong_rdy", 32'(vld), 32'h2);
        rr = 2'b10;
        next(); #1;
        check("zero_done_valid", 32'(vld), 32'h0);

        // Contention with both channels always valid and always ready.
        rv = 2'b11; rr = 2'b11;
        accum = {8'h20, 8'h10}; data = {8'h07, 8'h05}; opc = {3'b011, 3'b100};
        for (int op = 0; op < 4; op++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            exp_g = 2'b01;
`else
            exp_g = (op % 2 == 1) ? 2'b10 : 2'b01;
`endif
            exp_o = (exp_g == 2'b10) ? 8'h27 : 8'h15;
            #1 check("cont_grant", 32'(rdy), 32'(exp_g));
            next(); next(); next(); #1;
            check("cont_rsp_valid", 32'(vld), 32'(exp_g));
            check("cont_rsp_out", 32'(out), 32'(exp_o));
            next();
        end
        rv = 2'b00; rr = 2'b00;
        #1 check("cont_idle_ready", 32'(rdy), 32'h0);

        // Reset in the second EXEC cycle aborts the op.
        next();
        rv = 2'b01; accum[7:0] = 8'h0A; data[7:0] = 8'h0B; opc[2:0] = 3'b011;
        #1 check("abort_req_ready", 32'(rdy), 32'h1);
        next(); rv = 2'b00;
        next(); #1;
        check("abort_alu_accum", 32'(a_acc), 32'h0A);
        reset = 1'b1; #1;
        check("abort_rsp_valid", 32'(vld), 32'h0);
        check("abort_rsp_out", 32'(out), 32'h00);
        check("abort_rsp_zero", 32'(zero), 32'h0);
        check("abort_alu_bus", {a_acc, a_dat, 5'd0, a_opc, 8'd0}, 32'h0);
        next(); reset = 1'b0;
        rr = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1 check("abort_no_rsp", 32'(vld), 32'h0);
            next();
        end
        rr = 2'b10;
        rv = 2'b10; accum[15:8] = 8'h30; data[15:8] = 8'h0C; opc[5:3] = 3'b100;
        #1 check("post_req_ready", 32'(rdy), 32'h2);
        next(); rv = 2'b00;
        next(); next(); #1;
        check("post_rsp_valid", 32'(vld), 32'h2);
        check("post_rsp_out", 32'(out), 32'h3C);
        check("post_rsp_zero", 32'(zero), 32'h0);
        next(); #1;
        check("post_done_valid", 32'(vld), 32'h0);
        rr = 2'b00;

        // ALU_LAT=4 instance: response in cycle 6, bus stable over 5 EXEC cycles.
        b_rv = 2'b01; b_accum[7:0] = 8'h21; b_data[7:0] = 8'h22; b_opc[2:0] = 3'b101; b_rr = 2'b01;
        #1 check("lat4_req_ready", 32'(b_rdy), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            next(); b_rv = 2'b00; #1;
            check("lat4_alu_accum", 32'(b_acc), 32'h21);
            check("lat4_alu_data", 32'(b_dat), 32'h22);
            check("lat4_alu_opc", 32'(b_aopc), 32'h5);
            check("lat4_early_valid", 32'(b_vld), 32'h0);
        end
        next(); #1;
        check("lat4_rsp_valid", 32'(b_vld), 32'h1);
        check("lat4_rsp_out", 32'(b_out), 32'h43);
        check("lat4_rsp_zero", 32'(b_zero), 32'h0);
        next(); #1;
        check("lat4_done_valid", 32'(b_vld), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
